// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
// Multi-cycle shift-and-add-3 (double dabble) binary-to-BCD converter. It sits
// between the binary counter register and the 7-segment digit encoders. One
// input bit is consumed per clock. The last result is held so the display
// mux can sample it at any time.
//
// Ports:
//   clk      system clock
//   rst      synchronous, active-high reset
//   start    conversion request, sampled only while idle
//   bin_in   unsigned binary value, latched when start is accepted
//   busy     high while a conversion is in progress
//   done     one-cycle pulse when bcd_out/overflow update
//   bcd_out  BCD result, digit k at [4k+3:4k], k=0 is units
//   overflow last converted value did not fit in DIGITS decimal digits
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state;
  logic [BIN_W-1:0]   shreg;
  logic [BCD_W-1:0]   scratch;
  logic               sticky;
  logic [CNT_W-1:0]   cnt;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   scratch_nxt;
  logic [BIN_W-1:0]   shreg_nxt;
  logic               carry;
  logic               sticky_nxt;

  // Any digit >= 5 gets +3 so that the following doubling carries into the
  // next digit exactly when the doubled value reaches 10. There is no carry
  // between digits here; each result stays within 4 bits.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    logic [3:0]       d;
    r = s;
    for (int k = 0; k < DIGITS; k++) begin
      d = s[4*k +: 4];
      if (d >= 4'd5) begin
        r[4*k +: 4] = d + 4'd3;
      end
    end
    return r;
  endfunction

  // Adjust stage, then one-bit left shift of {scratch, shreg}. The bit leaving
  // the top digit means the running value has reached 10^DIGITS. The scratch
  // value keeps the value mod 10^DIGITS, so the low digits stay correct.
  always_comb begin
    adj = add3_digits(scratch);
    {carry, scratch_nxt, shreg_nxt} = {adj, shreg, 1'b0};
    sticky_nxt = sticky | carry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      shreg    <= '0;
      scratch  <= '0;
      sticky   <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shreg   <= bin_in;
            scratch <= '0;
            sticky  <= 1'b0;
            cnt     <= CNT_W'(BIN_W);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          shreg   <= shreg_nxt;
          scratch <= scratch_nxt;
          sticky  <= sticky_nxt;
          cnt     <= cnt - CNT_W'(1);
          // The last input bit goes in on this edge. Publish the post-shift
          // scratch and the sticky flag, including this edge's carry-out.
          if (cnt == CNT_W'(1)) begin
            bcd_out  <= scratch_nxt;
            overflow <= sticky_nxt;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq. It uses two instances: the default 8-bit/3-digit
// converter (a) and a 10-bit/3-digit one (b) for the overflow cases.
module tb_bin_to_bcd_seq;

  localparam int DIG = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [7:0]  bin_a;
  logic [9:0]  bin_b;
  logic        busy_a, done_a, ovf_a;
  logic        busy_b, done_b, ovf_b;
  logic [11:0] bcd_a, bcd_b;

  int vectors     = 0;
  int miscompares = 0;

  always #10 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(DIG)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .bin_in(bin_a),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a)
  );

  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(DIG)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .bin_in(bin_b),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b)
  );

  typedef struct {
    bit          wide;
    int unsigned val;
    logic [11:0] bcd;
    logic        ovf;
  } vec_t;

  // Decimal digits from plain division and modulo.
  function automatic logic [11:0] ref_bcd(input int unsigned v);
    logic [11:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int k = 0; k < DIG; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int unsigned v);
    int unsigned lim;
    lim = 1;
    for (int k = 0; k < DIG; k++) lim = lim * 10;
    return (v >= lim);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge. It starts one conversion and waits for done, then
  // checks the latency, the result, and that done is a single-cycle pulse.
  task automatic run_conv(input bit wide, input int unsigned v,
                          input logic [11:0] exp_bcd, input logic exp_ovf,
                          input string name);
    int n;
    if (wide) begin bin_b = 10'(v); start_b = 1'b1; end
    else      begin bin_a = 8'(v);  start_a = 1'b1; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    n = 0;
    while (!(wide ? done_b : done_a) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, n, wide ? 10 : 8);
    check({name, " bcd"}, wide ? bcd_b : bcd_a, exp_bcd);
    check({name, " ovf"}, wide ? ovf_b : ovf_a, exp_ovf);
    check({name, " busy_at_done"}, wide ? busy_b : busy_a, 0);
    @(negedge clk);
    check({name, " done_pulse"}, wide ? done_b : done_a, 0);
  endtask

  initial begin
    vec_t tbl[$];
    int   n;
    int   dones;
    logic [11:0] bcd;
    int unsigned v;

    tbl.push_back('{0, 0,    12'h000, 1'b0});
    tbl.push_back('{0, 255,  12'h255, 1'b0});
    tbl.push_back('{0, 123,  12'h123, 1'b0});
    tbl.push_back('{0, 99,   12'h099, 1'b0});
    tbl.push_back('{0, 1,    12'h001, 1'b0});
    tbl.push_back('{1, 999,  12'h999, 1'b0});
    tbl.push_back('{1, 1023, 12'h023, 1'b1});
    tbl.push_back('{1, 1000, 12'h000, 1'b1});

    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    bin_a = '0;
    bin_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", busy_a, 0);
    check("reset done", done_a, 0);
    check("reset bcd", bcd_a, 12'h000);
    check("reset ovf", ovf_a, 0);
    check("reset bcd_b", bcd_b, 12'h000);

    // Directed vectors from the table.
    for (int i = 0; i < tbl.size(); i++)
      run_conv(tbl[i].wide, tbl[i].val, tbl[i].bcd, tbl[i].ovf, $sformatf("tbl%0d", i));

    // Random vectors against the arithmetic reference.
    for (int i = 0; i < 25; i++) begin
      v = $urandom_range(0, 255);
      run_conv(0, v, ref_bcd(v), ref_ovf(v), $sformatf("rnd_a%0d", i));
    end
    for (int i = 0; i < 25; i++) begin
      v = $urandom_range(0, 1023);
      run_conv(1, v, ref_bcd(v), ref_ovf(v), $sformatf("rnd_b%0d", i));
    end

    // start held high: the next conversion is accepted in the done cycle, so
    // busy returns right after each done pulse and no idle cycle is spent.
    bin_a = 8'd200;
    start_a = 1'b1;
    n = 0;
    while (!done_a && n < 40) begin @(negedge clk); n++; end
    check("hold first done", n, 9);
    check("hold first bcd", bcd_a, 12'h200);
    @(negedge clk);
    check("hold rebusy", busy_a, 1);
    check("hold done low", done_a, 0);
    n = 1;
    while (!done_a && n < 40) begin @(negedge clk); n++; end
    check("hold period", n, 9);
    check("hold second bcd", bcd_a, 12'h200);
    start_a = 1'b0;
    @(negedge clk);
    check("hold stop busy", busy_a, 0);

    // Start pulses and bin_in changes while busy must not disturb the result.
    run_conv(0, 37, 12'h037, 1'b0, "pre_mid");
    bin_a = 8'd200;
    start_a = 1'b1;
    @(negedge clk);
    n = 0;
    for (int i = 1; i <= 5; i++) begin
      bin_a = 8'($urandom_range(0, 255));
      start_a = i[0];
      @(negedge clk);
      if (i == 2) check("mid hold bcd", bcd_a, 12'h037);
    end
    start_a = 1'b0;
    while (!done_a && n < 40) begin @(negedge clk); n++; end
    check("mid bcd", bcd_a, 12'h200);
    @(negedge clk);
    check("mid no requeue", busy_a, 0);

    // Reset on the fourth SHIFT edge aborts the conversion.
    run_conv(0, 255, 12'h255, 1'b0, "pre_abort");
    bin_a = 8'd7;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("abort busy", busy_a, 1);
      check("abort hold bcd", bcd_a, 12'h255);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy0", busy_a, 0);
    check("abort done0", done_a, 0);
    check("abort bcd0", bcd_a, 12'h000);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    check("abort no done", dones, 0);
    run_conv(0, 7, 12'h007, 1'b0, "post_abort");

    bcd = bcd_a;
    repeat (3) @(negedge clk);
    check("idle hold", bcd_a, bcd);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
